ps2_rx: RTL and testbench



---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_line_filter.sv | 44 ++++
 rtl/ps2_rx.sv | 153 +++++++++++++++
 tb/tb_ps2_rx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ============================================================================
// ps2_pkg : shared types, framing constants and parity helper for ps2_rx
// Revision: 1.0
// ============================================================================
`default_nettype none

package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  // True when data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_line_filter.sv
// ============================================================================
// ps2_line_filter : 2-flop synchronizer followed by a consecutive-sample debounce
// Revision: 1.0
// ============================================================================
`default_nettype none

module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic filtered
);

  logic       sync1;
  logic       sync2;
  logic [3:0] cnt;

  // The counter only advances while the synchronized line disagrees with the
  // output, so any agreeing sample restarts the qualification window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      filtered <= 1'b1;
      cnt      <= 4'd0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == filtered) begin
        cnt <= 4'd0;
      end else if (cnt == 4'(FILTER_LEN - 1)) begin
        filtered <= sync2;
        cnt      <= 4'd0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ps2_rx.sv
// ============================================================================
// ps2_rx : PS/2 receive deframer - edge detect, frame FSM, shifter and timeout
// Revision: 1.0
// ============================================================================
`default_nettype none

module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       timeout_err,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic clk_f;
  logic dat_f;
  logic clk_prev;
  logic fall;

  state_t       state,   state_nx;
  logic [3:0]   bit_cnt, bit_cnt_nx;
  logic [7:0]   shreg,   shreg_nx;
  logic         par,     par_nx;
  logic [TW-1:0] tcnt,   tcnt_nx;
  logic [7:0]   data_nx;
  logic         valid_nx;
  logic         perr_nx;
  logic         ferr_nx;
  logic         terr_nx;
  logic         tout;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk      (clk),
    .reset_n  (reset_n),
    .raw      (ps2_clk),
    .filtered (clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
    .clk      (clk),
    .reset_n  (reset_n),
    .raw      (ps2_dat),
    .filtered (dat_f)
  );

  assign fall = clk_prev & ~clk_f;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_prev    <= 1'b1;
      state       <= IDLE;
      bit_cnt     <= 4'd0;
      shreg       <= 8'h00;
      par         <= 1'b0;
      tcnt        <= '0;
      data        <= 8'h00;
      valid       <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      clk_prev    <= clk_f;
      state       <= state_nx;
      bit_cnt     <= bit_cnt_nx;
      shreg       <= shreg_nx;
      par         <= par_nx;
      tcnt        <= tcnt_nx;
      data        <= data_nx;
      valid       <= valid_nx;
      parity_err  <= perr_nx;
      frame_err   <= ferr_nx;
      timeout_err <= terr_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    par_nx     = par;
    tcnt_nx    = tcnt;
    data_nx    = data;
    valid_nx   = 1'b0;
    perr_nx    = 1'b0;
    ferr_nx    = 1'b0;
    terr_nx    = 1'b0;
    tout       = 1'b0;

    // A fall arriving in the expiry cycle takes precedence over the timeout.
    if (state == IDLE || fall) begin
      tcnt_nx = '0;
    end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
      tout = 1'b1;
    end else begin
      tcnt_nx = tcnt + TW'(1);
    end

    if (tout) begin
      terr_nx    = 1'b1;
      state_nx   = IDLE;
      tcnt_nx    = '0;
      bit_cnt_nx = 4'd0;
    end else if (fall) begin
      unique case (state)
        IDLE: begin
          if (dat_f == START_BIT) begin
            state_nx   = DATA;
            bit_cnt_nx = 4'd0;
          end
        end
        DATA: begin
          shreg_nx   = {dat_f, shreg[7:1]};
          bit_cnt_nx = bit_cnt + 4'd1;
          if (bit_cnt == 4'(DATA_BITS - 1)) begin
            state_nx = PARITY;
          end
        end
        PARITY: begin
          par_nx   = dat_f;
          state_nx = STOP;
        end
        STOP: begin
          state_nx = IDLE;
          if (dat_f != STOP_BIT) begin
            ferr_nx = 1'b1;
          end else if (!odd_parity_ok(shreg, par)) begin
            perr_nx = 1'b1;
          end else begin
            data_nx  = shreg;
            valid_nx = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ps2_rx.sv
// ============================================================================
// tb_ps2_rx : directed self-checking bench for ps2_rx
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ps2_rx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] data;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       timeout_err;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int n_valid = 0, n_perr = 0, n_ferr = 0, n_tout = 0;
  logic [7:0] vq[$];
  time tout_t = 0;
  time fall_t = 0;

  ps2_rx #(.FILTER_LEN(4), .TIMEOUT_CYCLES(200)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ps2_clk     (ps2_clk),
    .ps2_dat     (ps2_dat),
    .data        (data),
    .valid       (valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  always #500 clk = ~clk;

  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      vq.push_back(data);
    end
    if (parity_err) n_perr++;
    if (frame_err) n_ferr++;
    if (timeout_err) begin
      n_tout++;
      tout_t = $time;
    end
  end

  initial begin
    #(64'd200_000_000);
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame bits, index 0 is the start bit.
  function automatic logic [10:0] mk(input logic [7:0] b, input logic par_good, input logic stop);
    logic p;
    p = par_good ? ~(^b) : (^b);
    return {stop, p, b, 1'b0};
  endfunction

  // lat_kind: {valid, parity_err, frame_err} expected 7 cycles after the stop fall.
  task automatic send(input logic [10:0] bits, input int nbits, input int glitch_bit,
                      input logic [2:0] lat_kind);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      cyc(20);
      ps2_clk = 1'b0;
      fall_t  = $time;
      if (i == glitch_bit) begin
        ps2_dat = ~bits[i];
        cyc(3);
        ps2_dat = bits[i];
        cyc(37);
      end else if (i == 10 && lat_kind != 3'b000) begin
        cyc(6);
        chk("lat_early", {valid, parity_err, frame_err}, 3'b000);
        cyc(1);
        chk("lat_exact", {valid, parity_err, frame_err}, lat_kind);
        cyc(33);
      end else begin
        cyc(40);
      end
      ps2_clk = 1'b1;
      cyc(20);
    end
    ps2_dat = 1'b1;
  endtask

  initial begin
    int v0, p0, f0, t0;
    time last_fall;
    int d;

    reset_n = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    cyc(3);
    chk("rst_data", data, 8'h00);
    chk("rst_pulses", {valid, parity_err, frame_err, timeout_err}, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    reset_n = 1'b1;
    cyc(10);

    // 16 back-to-back good frames
    for (int b = 0; b < 16; b++) send(mk(8'(b), 1'b1, 1'b1), 11, -1, 3'b100);
    cyc(5);
    chk("stream_nvalid", n_valid, 16);
    chk("stream_errs", n_perr + n_ferr + n_tout, 0);
    for (int b = 0; b < 16; b++) chk("stream_byte", vq[b], 8'(b));
    chk("stream_data", data, 8'h0F);

    // bad parity
    v0 = n_valid; p0 = n_perr;
    send(mk(8'hA5, 1'b0, 1'b1), 11, -1, 3'b010);
    cyc(5);
    chk("perr_count", n_perr - p0, 1);
    chk("perr_novalid", n_valid - v0, 0);
    chk("perr_data", data, 8'h0F);

    // bad stop bit
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    send(mk(8'h3C, 1'b1, 1'b0), 11, -1, 3'b001);
    cyc(5);
    chk("ferr_count", n_ferr - f0, 1);
    chk("ferr_other", (n_valid - v0) + (n_perr - p0), 0);
    chk("ferr_data", data, 8'h0F);

    // partial frame then silence
    t0 = n_tout;
    send(mk(8'h0A, 1'b1, 1'b1), 5, -1, 3'b000);
    last_fall = fall_t;
    chk("tout_busy_mid", busy, 1'b1);
    cyc(300);
    d = int'((tout_t - last_fall) / 1000);
    chk("tout_count", n_tout - t0, 1);
    chk("tout_latency", (d >= 195 && d <= 215), 1'b1);
    chk("tout_busy", busy, 1'b0);
    chk("tout_data", data, 8'h0F);
    send(mk(8'h3C, 1'b1, 1'b1), 11, -1, 3'b100);
    cyc(5);
    chk("after_tout_data", data, 8'h3C);

    // glitches: clock in idle, data at a falling edge inside a frame
    v0 = n_valid; p0 = n_perr; f0 = n_ferr; t0 = n_tout;
    ps2_clk = 1'b0;
    cyc(3);
    ps2_clk = 1'b1;
    cyc(15);
    chk("glitch_idle_busy", busy, 1'b0);
    chk("glitch_idle_pulses", (n_valid - v0) + (n_perr - p0) + (n_ferr - f0) + (n_tout - t0), 0);
    send(mk(8'h81, 1'b1, 1'b1), 11, 3, 3'b100);
    cyc(5);
    chk("glitch_data", data, 8'h81);
    chk("glitch_errs", (n_perr - p0) + (n_ferr - f0) + (n_tout - t0), 0);

    // reset mid-frame
    p0 = n_perr; f0 = n_ferr; t0 = n_tout;
    send(mk(8'h55, 1'b1, 1'b1), 5, -1, 3'b000);
    reset_n = 1'b0;
    cyc(5);
    chk("mid_rst_data", data, 8'h00);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_pulses", {valid, parity_err, frame_err, timeout_err}, 4'b0000);
    reset_n = 1'b1;
    cyc(10);
    v0 = n_valid;
    send(mk(8'h55, 1'b1, 1'b1), 11, -1, 3'b100);
    cyc(5);
    chk("post_rst_valid", n_valid - v0, 1);
    chk("post_rst_data", data, 8'h55);
    chk("post_rst_errs", (n_perr - p0) + (n_ferr - f0) + (n_tout - t0), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
